sll_seq32: RTL
==============

// Module: sll_seq32
// PURPOSE
//   Multi-cycle logical left shifter: the left-direction counterpart to the
//   combinational arithmetic right shifter in the ALU shifter group.
//   Accepts an operand and shift amount via start/ready, applies one
//   power-of-two stage per cycle (16,8,4,2,1) and holds the result until
//   acknowledged. Also reports whether any 1 bits were shifted out.
// PARAMETERS
//   DATA_W   32   operand/result width; must equal 2**AMT_W
//   AMT_W    5    shift-amount width; also the number of SHIFT cycles
// PORTS
//   clock         in   1       rising-edge clock
//   reset         in   1       asynchronous, active-low reset
//   start         in   1       request; accepted when start & ready at a clock edge
//   data_in       in   DATA_W  operand, sampled on acceptance
//   shiftamt      in   AMT_W   left-shift distance 0..DATA_W-1, sampled on acceptance
//   ready         out  1       1 only in IDLE
//   busy          out  1       1 in SHIFT or DONE
//   result        out  DATA_W  data_in << shiftamt, zero-filled from bit 0
//   bits_lost     out  1       1 if any 1 bit was shifted past bit DATA_W-1
//   result_valid  out  1       1 only in DONE
//   result_ack    in   1       consumer accepts result; sampled only when result_valid=1
// BEHAVIOUR
//   - States: IDLE, SHIFT, DONE. Reset (reset=0, async) forces IDLE, stage
//     counter 0, result=0, bits_lost=0, result_valid=0, busy=0, ready=1.
//   - IDLE: ready=1. On edge with start=1: latch data_in into working reg,
//     shiftamt into amt reg, clear bits_lost, stage counter <= AMT_W-1, -> SHIFT.
//     start=0: remain IDLE, result/bits_lost hold last values.
//   - SHIFT: each edge, stage s (AMT_W-1 down to 0): if amt[s]=1, working
//     <= working << 2**s and bits_lost |= OR of working[DATA_W-1 -: 2**s];
//     else working unchanged. After stage 0 -> DONE. Exactly AMT_W cycles,
//     independent of shiftamt value (no early exit; shiftamt=0 also takes 5).
//   - Latency: request accepted at edge k -> result_valid=1 after edge k+AMT_W.
//   - DONE: result_valid=1, result/bits_lost stable. result_ack=1 at an edge
//     -> IDLE (result_valid drops, result/bits_lost hold). ack=0 -> stay DONE.
//   - start asserted while busy is ignored (no queueing); ready=0 makes this visible.
//   - result_ack outside DONE is ignored. A new start cannot be accepted in the
//     same edge as the ack; earliest acceptance is the following edge.
//   - reset asserted mid-SHIFT or in DONE aborts immediately; in-flight result
//     is discarded, all outputs return to reset values asynchronously.
//   - result equals working reg; during SHIFT it shows intermediate values and
//     must only be consumed when result_valid=1.
//   - Widths: all shifts zero-fill; no sign handling; amt reg is AMT_W bits so
//     shift >= DATA_W is unrepresentable.
// TESTING
//   1. data_in=0x0000_0001, shiftamt=31, start 1 cycle -> after 5 edges
//      result=0x8000_0000, bits_lost=0, result_valid=1 held until ack.
//   2. data_in=0xF000_000F, shiftamt=4 -> result=0x0000_00F0, bits_lost=1;
//      shiftamt=0 on same operand -> result=0xF000_000F, bits_lost=0, still 5 cycles.
//   3. Start accepted, start re-pulsed with 0xFFFF_FFFF during SHIFT/DONE ->
//      ignored; result matches first request; ready=0 throughout.
//   4. Hold result_ack=0 for 10 cycles in DONE -> result_valid and result
//      stable; ack=1 -> IDLE next edge, ready=1; start same cycle as ack not taken.
//   5. Assert reset at stage 2 of 0x1234_5678<<8 -> outputs zero immediately,
//      ready=1; next request 0x1234_5678<<8 -> 0x3456_7800, bits_lost=1.
//   6. Random sweep 1000 ops vs reference (data<<amt, lost=|(data>>(32-amt)))
//      with random ack delays -> zero mismatches.

Source files
------------

// File: rtl/sll_seq32.sv
// ============================================================================
// Module      : sll_seq32
// Description : Multi-cycle logical left shifter, one power-of-two stage per
//               cycle, with start/ready request and valid/ack result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sll_seq32 #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  shiftamt,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              bits_lost,
    output logic              result_valid,
    input  logic              result_ack
);

    localparam int STG_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;
    localparam logic [STG_W-1:0] C_LAST_STAGE = STG_W'(AMT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic               lost_q, lost_d;

    logic [DATA_W-1:0]  w_stage_work [AMT_W];
    logic [AMT_W-1:0]   w_stage_lost;
    logic [DATA_W-1:0]  w_sel_work;
    logic               w_sel_lost;
    logic               w_take;

    // Each stage s shifts by 2**s; the bits it pushes out are the top 2**s.
    for (genvar s = 0; s < AMT_W; s++) begin : g_stage
        localparam int SH = 1 << s;
        assign w_stage_work[s] = work_q << SH;
        assign w_stage_lost[s] = |work_q[DATA_W-1 -: SH];
    end

    always_comb begin
        w_sel_work = w_stage_work[0];
        w_sel_lost = w_stage_lost[0];
        w_take     = amt_q[0];
        for (int s = 1; s < AMT_W; s++) begin
            if (stage_q == STG_W'(s)) begin
                w_sel_work = w_stage_work[s];
                w_sel_lost = w_stage_lost[s];
                w_take     = amt_q[s];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        amt_d   = amt_q;
        stage_d = stage_q;
        lost_d  = lost_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = data_in;
                    amt_d   = shiftamt;
                    lost_d  = 1'b0;
                    stage_d = C_LAST_STAGE;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_take) begin
                    work_d = w_sel_work;
                    lost_d = lost_q | w_sel_lost;
                end
                // Fixed AMT_W cycles regardless of amount: no early exit.
                if (stage_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    stage_d = stage_q - STG_W'(1);
                end
            end
            ST_DONE: begin
                if (result_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            amt_q   <= '0;
            stage_q <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            stage_q <= stage_d;
            lost_q  <= lost_d;
        end
    end

    assign ready        = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = work_q;
    assign bits_lost    = lost_q;

endmodule

`default_nettype wire
